// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants and state type for the BCD <-> binary conversion path.
package bcd_to_bin_seq_pkg;

  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for the BCD-to-binary converter: input side and result side.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 16
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      bin_out;
  logic                  err;

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );

endinterface

// File: rtl/bcd_to_bin_seq_digit_mac.sv
// One Horner step: acc*10 + digit at OUT_W width, plus a non-decimal digit flag.
module bcd_digit_mac
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic [OUT_W-1:0]   acc_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [OUT_W-1:0]   acc_o,
  output logic               digit_bad_o
);

  // *10 as shift-and-add; carries beyond OUT_W are dropped (modulo wrap)
  assign acc_o       = (acc_i << 3) + (acc_i << 1) + OUT_W'(digit_i);
  assign digit_bad_o = (digit_i > DIGIT_W'(MAX_DIGIT));

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock. Define BCD_CHECK_EN to flag non-decimal nibbles.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_to_bin_seq_if.slave   bus_if
);

  localparam int SR_W  = DIGIT_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   bin_q, bin_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               err_out_q, err_out_d;

  logic [OUT_W-1:0]   mac_acc;
  logic               digit_bad;
  logic               err_next;

  bcd_digit_mac #(
    .OUT_W (OUT_W)
  ) u_mac (
    .acc_i       (acc_q),
    .digit_i     (sr_q[SR_W-1 -: DIGIT_W]),
    .acc_o       (mac_acc),
    .digit_bad_o (digit_bad)
  );

`ifdef BCD_CHECK_EN
  assign err_next = err_q | digit_bad;
`else
  logic unused_digit_bad;
  assign unused_digit_bad = digit_bad;
  assign err_next         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bin_d     = bin_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    err_out_d = err_out_q;
    unique case (state_q)
      IDLE: begin
        if (bus_if.in_valid) begin
          sr_d    = bus_if.bcd_in;
          acc_d   = '0;
          err_d   = 1'b0;
          cnt_d   = CNT_W'(DIGITS - 1);
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = mac_acc;
        sr_d  = sr_q << DIGIT_W;
        err_d = err_next;
        if (cnt_q == '0) begin
          // An invalid digit anywhere forces a zero result alongside err
          bin_d     = err_next ? '0 : mac_acc;
          err_out_d = err_next;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (bus_if.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      bin_q     <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bin_q     <= bin_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_out_q <= err_out_d;
    end
  end

  assign bus_if.in_ready  = (state_q == IDLE);
  assign bus_if.out_valid = (state_q == DONE);
  assign bus_if.bin_out   = bin_q;
  assign bus_if.err       = err_out_q;

endmodule
